uart_rx_fifo: RTL

Byte FIFO downstream of the UART receiver. Absorbs bytes the receiver presents on its ready/valid output and holds them until the CPU's memory-mapped UART read path takes them. This keeps back-to-back frames from being lost while software is busy. It reports occupancy and a sticky overflow flag for the UART status register.

---
 rtl/uart_rx_fifo.sv | 125 ++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Byte FIFO between the UART receiver's ready/valid output and the CPU's
//   memory-mapped read path. It uses first-word fall-through, and reports
//   occupancy (Count) plus a sticky Overflow flag for the status register.
//
//   Build option UART_RX_FIFO_DROP_EN:
//     defined   - drop mode. InReady is tied high. A byte arriving while the
//                 FIFO is full, with no pop in the same cycle, is discarded
//                 and sets Overflow.
//     undefined - backpressure mode. InReady = !Full, Overflow stays 0 and
//                 OverflowClear is ignored.
//
//   Reset is synchronous and active-low. The storage array is never reset;
//   only the pointers and the flag are.

module uart_rx_fifo #(
  parameter int DepthLog2 = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [7:0]           InData,
  input  logic                 InValid,
  output logic                 InReady,
  output logic [7:0]           OutData,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [DepthLog2:0]   Count,
  output logic                 Overflow,
  input  logic                 OverflowClear
);

  localparam int Depth = 1 << DepthLog2;

  // Count value that means "every entry is occupied".
  localparam logic [DepthLog2:0] FullCount = {1'b1, {DepthLog2{1'b0}}};

  logic [7:0]           Mem [Depth];
  logic [DepthLog2:0]   WrPtr;
  logic [DepthLog2:0]   RdPtr;
  logic [DepthLog2-1:0] WrIdx;
  logic [DepthLog2-1:0] RdIdx;
  logic                 Empty;
  logic                 Full;
  logic                 Push;
  logic                 Pop;
  logic                 Discard;

  assign WrIdx = WrPtr[DepthLog2-1:0];
  assign RdIdx = RdPtr[DepthLog2-1:0];

  // The extra pointer MSB means plain subtraction gives the occupancy,
  // even after the pointers wrap.
  assign Count = WrPtr - RdPtr;
  assign Empty = (Count == '0);
  assign Full  = (Count == FullCount);

  assign OutValid = ~Empty;
  assign Pop      = OutValid & OutReady;

`ifdef UART_RX_FIFO_DROP_EN
  // The receiver never stalls. A pop in the same cycle makes room, so a
  // full FIFO still accepts a byte when it is popped at the same time.
  assign InReady = 1'b1;
  assign Push    = InValid & (~Full | Pop);
  assign Discard = InValid & Full & ~Pop;
`else
  // InReady depends only on registered state. A same-cycle pop does not
  // open a slot until the next cycle.
  assign InReady = ~Full;
  assign Push    = InValid & InReady;
  assign Discard = 1'b0;
`endif

  // Head byte, forced to zero when there is nothing to read.
  always_comb begin
    OutData = 8'h00;
    if (OutValid) begin
      OutData = Mem[RdIdx];
    end
  end

  // Pointer update. Pushes and pops are ignored on a reset edge.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      WrPtr <= '0;
      RdPtr <= '0;
    end else begin
      if (Push) begin
        WrPtr <= WrPtr + 1'b1;
      end
      if (Pop) begin
        RdPtr <= RdPtr + 1'b1;
      end
    end
  end

  // Storage write. The array has no reset, so only accepted bytes land here.
  always_ff @(posedge Clock) begin
    if (Reset && Push) begin
      Mem[WrIdx] <= InData;
    end
  end

`ifdef UART_RX_FIFO_DROP_EN
  // Sticky overflow flag. A discard in the same cycle as a clear wins.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      Overflow <= 1'b0;
    end else if (Discard) begin
      Overflow <= 1'b1;
    end else if (OverflowClear) begin
      Overflow <= 1'b0;
    end
  end
`else
  // Nothing is ever discarded in backpressure mode.
  logic unused_clear;
  logic unused_discard;

  assign Overflow       = 1'b0;
  assign unused_clear   = OverflowClear;
  assign unused_discard = Discard;
`endif

endmodule
